// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: computes A+B+Cin LSB-first on one shared full adder.
// Latency: WIDTH cycles from the accepting Start edge to the one-cycle Done pulse.
// Backpressure: none; Start is ignored while Busy, and accepted again in the Done cycle.
//
// Ports:
//   clk, rst_n      - clock; asynchronous active-low reset with synchronised release
//   Start, Clear    - begin an addition / synchronous abort (Clear wins over Start)
//   A, B, Cin       - operands and carry-in, captured only on the accepting edge
//   Busy, Done      - addition in progress / one-cycle completion pulse
//   Sum, Cout       - registered result and carry of the last completed addition
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic             Clear,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        ADD  = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] s_sr;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             done_q;
    logic [1:0]       rst_sync;

    logic             fa_sum;
    logic             fa_cout;
    logic             accept;
    logic             adding;
    logic             last_bit;

    // Reset release is retimed so an edge coincident with (or just after)
    // deassertion can never accept a Start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    FullAdder_1b u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    always_comb begin
        accept   = (state == IDLE) && Start && !Clear && rst_sync[1];
        adding   = (state == ADD) && !Clear;
        last_bit = adding && (cnt == LAST);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = ADD;
            ADD:  if (Clear || (cnt == LAST)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        Busy = (state == ADD);
        Done = done_q;
    end

    // Datapath: operand shifters, carry flop, bit counter and result registers.
    // On the final bit the result is taken from the adder output directly so the
    // last sum bit lands in Sum on the same edge it is computed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            s_sr   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            done_q <= 1'b0;
            Sum    <= '0;
            Cout   <= 1'b0;
        end else begin
            done_q <= last_bit;
            if (accept) begin
                a_sr  <= A;
                b_sr  <= B;
                s_sr  <= '0;
                carry <= Cin;
                cnt   <= '0;
            end else if (adding) begin
                a_sr  <= a_sr >> 1;
                b_sr  <= b_sr >> 1;
                s_sr  <= {fa_sum, s_sr[WIDTH-1:1]};
                carry <= fa_cout;
                cnt   <= cnt + CW'(1);
                if (last_bit) begin
                    Sum  <= {fa_sum, s_sr[WIDTH-1:1]};
                    Cout <= fa_cout;
                end
            end
        end
    end

endmodule

// One-bit full adder shared by the serial datapath.
// Latency: combinational.
// Backpressure: none.
module FullAdder_1b (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    always_comb begin
        sum  = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8).
// Expected results come from plain integer addition of the operands.
// Outputs are sampled 1 time unit after each rising edge.
module tb_serial_adder_ctrl;

    logic       clk;
    logic       rst_n;
    logic       Start;
    logic       Clear;
    logic [7:0] A;
    logic [7:0] B;
    logic       Cin;
    logic       Busy;
    logic       Done;
    logic [7:0] Sum;
    logic       Cout;

    int checks = 0;
    int errors = 0;

    // Reference model: result of the last completed addition
    logic [7:0] m_sum;
    logic       m_cout;

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .Start (Start),
        .Clear (Clear),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .Busy  (Busy),
        .Done  (Done),
        .Sum   (Sum),
        .Cout  (Cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one addition and follow it to completion. With hold_start set,
    // Start stays high with scrambled operands throughout Busy (and into the
    // Done cycle).
    task automatic add_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                          input bit hold_start);
        logic [8:0] full;
        full  = {1'b0, a} + {1'b0, b} + 9'(c);
        Start = 1'b1;
        Clear = 1'b0;
        A     = a;
        B     = b;
        Cin   = c;
        step();
        for (int i = 1; i <= 8; i++) begin
            Start = hold_start;
            A     = 8'($urandom);
            B     = 8'($urandom);
            Cin   = 1'($urandom);
            chk("busy_during_add", Busy, 1);
            chk("no_early_done", Done, 0);
            chk("sum_held", Sum, m_sum);
            chk("cout_held", Cout, m_cout);
            step();
        end
        chk("done_pulse", Done, 1);
        chk("busy_low_at_done", Busy, 0);
        chk("sum_result", Sum, full[7:0]);
        chk("cout_result", Cout, full[8]);
        m_sum  = full[7:0];
        m_cout = full[8];
    endtask

    // Return to idle after a completion and confirm Done lasted one cycle.
    task automatic settle();
        Start = 1'b0;
        step();
        chk("done_one_cycle", Done, 0);
        chk("busy_idle", Busy, 0);
        chk("sum_idle_hold", Sum, m_sum);
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;

        rst_n  = 1'b0;
        Start  = 1'b0;
        Clear  = 1'b0;
        A      = 8'h00;
        B      = 8'h00;
        Cin    = 1'b0;
        m_sum  = 8'h00;
        m_cout = 1'b0;

        // Reset state
        #2;
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_sum", Sum, 0);
        chk("rst_cout", Cout, 0);
        #5;
        rst_n = 1'b1;
        step();
        step();
        step();
        chk("idle_busy", Busy, 0);

        // Directed additions
        add_op(8'h5A, 8'h33, 1'b0, 1'b0);
        settle();
        add_op(8'hFF, 8'h01, 1'b0, 1'b0);
        settle();
        add_op(8'hFF, 8'h00, 1'b1, 1'b0);
        settle();

        // Start held with changing operands, then back-to-back in the Done cycle
        add_op(8'hC3, 8'h4E, 1'b1, 1'b1);
        add_op(8'h01, 8'h02, 1'b0, 1'b0);
        settle();

        // Clear on the fourth ADD edge
        Start = 1'b1;
        A     = 8'h77;
        B     = 8'h99;
        Cin   = 1'b1;
        step();
        Start = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("busy_before_clear", Busy, 1);
        Clear = 1'b1;
        step();
        Clear = 1'b0;
        chk("clear_busy", Busy, 0);
        chk("clear_no_done", Done, 0);
        chk("clear_sum_kept", Sum, m_sum);
        chk("clear_cout_kept", Cout, m_cout);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("clear_never_done", Done, 0);
        end
        chk("clear_sum_still", Sum, m_sum);

        // Clear beats Start in IDLE
        Start = 1'b1;
        Clear = 1'b1;
        step();
        chk("clear_over_start", Busy, 0);
        Start = 1'b0;
        Clear = 1'b0;

        // Asynchronous reset in the middle of an addition
        Start = 1'b1;
        A     = 8'hAB;
        B     = 8'hCD;
        Cin   = 1'b0;
        step();
        Start = 1'b0;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", Busy, 0);
        chk("arst_done", Done, 0);
        chk("arst_sum", Sum, 0);
        chk("arst_cout", Cout, 0);
        m_sum  = 8'h00;
        m_cout = 1'b0;
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("arst_no_done", Done, 0);
        end
        add_op(8'h10, 8'h20, 1'b0, 1'b0);
        settle();

        // Randomised additions, alternating idle gap and back-to-back
        for (int n = 0; n < 24; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            if (n % 5 == 0) ra = 8'hFF;
            add_op(ra, rb, rc, 1'b0);
            if (n % 2 == 0) settle();
        end
        settle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
